// File: rtl/axi_fsrc_pkg.sv
// Constants and helpers shared by the TX and RX FSRC blocks.
// Widths are derived from the beat geometry, and the hole marker is defined here.
package axi_fsrc_pkg;

    localparam int FSRC_NUM_OF_CHANNELS   = 4;
    localparam int FSRC_SAMPLE_DATA_WIDTH = 16;
    localparam int FSRC_DATA_WIDTH        = 256;
    localparam int FSRC_CHANNEL_WIDTH     = FSRC_DATA_WIDTH / FSRC_NUM_OF_CHANNELS;
    localparam int FSRC_SPC               = FSRC_CHANNEL_WIDTH / FSRC_SAMPLE_DATA_WIDTH;

    // Hole marker: MSB set, all other bits clear.
    localparam logic [FSRC_SAMPLE_DATA_WIDTH-1:0] FSRC_INVALID_SAMPLE =
        {1'b1, {(FSRC_SAMPLE_DATA_WIDTH-1){1'b0}}};

    function automatic logic [63:0] fsrc_invalid_sample(input int sample_width);
        return 64'd1 << (sample_width - 1);
    endfunction

    function automatic int fsrc_channel_width(input int data_width, input int num_channels);
        return data_width / num_channels;
    endfunction

    function automatic int fsrc_spc(input int data_width, input int num_channels,
                                    input int sample_width);
        return (data_width / num_channels) / sample_width;
    endfunction

endpackage

// File: rtl/rx_fsrc_compact.sv
// Per-channel packing buffer of 2*SPC samples.
// It shifts out one output beat and appends the kept input samples at the shared fill point.
module rx_fsrc_compact
    import axi_fsrc_pkg::*;
#(
    parameter int SAMPLE_DATA_WIDTH = FSRC_SAMPLE_DATA_WIDTH,
    parameter int SPC               = FSRC_SPC,
    parameter int FILL_WIDTH        = $clog2(2 * SPC)
) (
    input  logic                             clk,
    input  logic [SPC*SAMPLE_DATA_WIDTH-1:0] in_data_i,
    input  logic [SPC-1:0]                   hole_mask_i,
    input  logic                             append_i,
    input  logic                             shift_i,
    input  logic [FILL_WIDTH-1:0]            fill_i,
    output logic [SPC-1:0]                   invalid_o,
    output logic [SPC*SAMPLE_DATA_WIDTH-1:0] out_data_o
);

    localparam int DEPTH = 2 * SPC;
    localparam logic [63:0] INVALID_FULL = fsrc_invalid_sample(SAMPLE_DATA_WIDTH);
    localparam logic [SAMPLE_DATA_WIDTH-1:0] INVALID_SAMPLE = INVALID_FULL[SAMPLE_DATA_WIDTH-1:0];
    localparam logic [FILL_WIDTH:0] SPC_W   = (FILL_WIDTH+1)'(SPC);
    localparam logic [FILL_WIDTH:0] DEPTH_W = (FILL_WIDTH+1)'(DEPTH);
    localparam logic [FILL_WIDTH:0] ONE_W   = (FILL_WIDTH+1)'(1);

    typedef logic [SAMPLE_DATA_WIDTH-1:0] sample_t;

    sample_t buf_q [DEPTH];
    sample_t buf_d [DEPTH];

    for (genvar gi = 0; gi < SPC; gi++) begin : g_lane
        assign invalid_o[gi] =
            (in_data_i[gi*SAMPLE_DATA_WIDTH +: SAMPLE_DATA_WIDTH] == INVALID_SAMPLE);
        assign out_data_o[gi*SAMPLE_DATA_WIDTH +: SAMPLE_DATA_WIDTH] = buf_q[gi];
    end

    always_comb begin : p_pack
        logic [FILL_WIDTH:0] pos;
        // NOTE: combinational blocks use blocking '=' so later statements see earlier
        // results; starting from buf_q and pos keeps every path assigned (no latch).
        buf_d = buf_q;
        pos   = {1'b0, fill_i};
        if (shift_i) begin
            for (int i = 0; i < SPC; i++) begin
                buf_d[i] = buf_q[i+SPC];
            end
            pos = pos - SPC_W;
        end
        if (append_i) begin
            for (int j = 0; j < SPC; j++) begin
                if (!hole_mask_i[j] && (pos < DEPTH_W)) begin
                    buf_d[pos[FILL_WIDTH-1:0]] = in_data_i[j*SAMPLE_DATA_WIDTH +: SAMPLE_DATA_WIDTH];
                    pos = pos + ONE_W;
                end
            end
        end
    end

    // NOTE: sample storage has no reset; the fill counter in the parent decides what is live.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: rtl/rx_fsrc.sv
// RX FSRC hole remover: drops positions flagged invalid on the reference channel
// and repacks the remaining samples of every channel into dense output beats.
module rx_fsrc
    import axi_fsrc_pkg::*;
#(
    parameter int NUM_OF_CHANNELS   = FSRC_NUM_OF_CHANNELS,
    parameter int SAMPLE_DATA_WIDTH = FSRC_SAMPLE_DATA_WIDTH,
    parameter int DATA_WIDTH        = FSRC_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NUM_OF_CHANNELS-1:0] conv_mask,
    input  logic                       clear_stats,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [31:0]                hole_count,
    output logic                       mismatch
);

    localparam int CHANNEL_WIDTH = fsrc_channel_width(DATA_WIDTH, NUM_OF_CHANNELS);
    localparam int SPC           = fsrc_spc(DATA_WIDTH, NUM_OF_CHANNELS, SAMPLE_DATA_WIDTH);
    localparam int FILL_WIDTH    = $clog2(2 * SPC);
    localparam logic [FILL_WIDTH-1:0] SPC_F = FILL_WIDTH'(SPC);

    logic                  enable_q;
    logic [FILL_WIDTH-1:0] fill_q, fill_d;
    logic                  out_valid_q, out_valid_d;
    logic [31:0]           hole_count_q, hole_count_d;
    logic                  mismatch_q, mismatch_d;

    logic [SPC-1:0]        inv_pat [NUM_OF_CHANNELS];
    logic [SPC-1:0]        ref_pat;
    logic [SPC-1:0]        hole_mask;
    logic                  pattern_diff;
    logic                  toggle, in_fire, out_fire;
    logic [FILL_WIDTH-1:0] keep_cnt;
    logic [31:0]           hole_add;
    logic [32:0]           hole_sum;

    // Descending scan so the lowest enabled channel wins; channel 0 if none enabled.
    always_comb begin
        ref_pat = inv_pat[0];
        for (int ii = NUM_OF_CHANNELS - 1; ii >= 0; ii--) begin
            if (conv_mask[ii]) ref_pat = inv_pat[ii];
        end
    end

    always_comb begin
        pattern_diff = 1'b0;
        for (int ii = 0; ii < NUM_OF_CHANNELS; ii++) begin
            if (conv_mask[ii] && (inv_pat[ii] != ref_pat)) pattern_diff = 1'b1;
        end
    end

    assign toggle    = (enable != enable_q);
    assign in_ready  = !reset && !toggle && ((fill_q < SPC_F) || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign hole_mask = enable_q ? ref_pat : '0;
    assign keep_cnt  = FILL_WIDTH'($countones(~hole_mask));
    assign hole_add  = 32'($countones(hole_mask));
    assign hole_sum  = {1'b0, hole_count_q} + {1'b0, hole_add};

    always_comb begin
        fill_d       = fill_q;
        hole_count_d = hole_count_q;
        mismatch_d   = mismatch_q;
        if (toggle) begin
            fill_d = '0;
        end else begin
            if (out_fire) fill_d = fill_d - SPC_F;
            if (in_fire)  fill_d = fill_d + keep_cnt;
        end
        out_valid_d = (fill_d >= SPC_F);
        if (clear_stats) begin
            hole_count_d = '0;
            mismatch_d   = 1'b0;
        end else if (in_fire && enable_q) begin
            hole_count_d = hole_sum[32] ? '1 : hole_sum[31:0];
            if (pattern_diff) mismatch_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q     <= 1'b0;
            fill_q       <= '0;
            out_valid_q  <= 1'b0;
            hole_count_q <= '0;
            mismatch_q   <= 1'b0;
        end else begin
            enable_q     <= enable;
            fill_q       <= fill_d;
            out_valid_q  <= out_valid_d;
            hole_count_q <= hole_count_d;
            mismatch_q   <= mismatch_d;
        end
    end

    for (genvar gc = 0; gc < NUM_OF_CHANNELS; gc++) begin : g_ch
        rx_fsrc_compact #(
            .SAMPLE_DATA_WIDTH(SAMPLE_DATA_WIDTH),
            .SPC              (SPC),
            .FILL_WIDTH       (FILL_WIDTH)
        ) u_compact (
            .clk        (clk),
            .in_data_i  (in_data[gc*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
            .hole_mask_i(hole_mask),
            .append_i   (in_fire),
            .shift_i    (out_fire),
            .fill_i     (fill_q),
            .invalid_o  (inv_pat[gc]),
            .out_data_o (out_data[gc*CHANNEL_WIDTH +: CHANNEL_WIDTH])
        );
    end

    assign out_valid  = out_valid_q;
    assign hole_count = hole_count_q;
    assign mismatch   = mismatch_q;

endmodule

// File: tb/tb_rx_fsrc.sv
// Directed bench for rx_fsrc with a queue scoreboard fed by a sample-level packing model.
// Each cycle the monitor compares handshakes, data, counters and flags against the model.
module tb_rx_fsrc;
    import axi_fsrc_pkg::*;

    localparam logic [15:0] H = 16'h8000;

    logic         clk = 1'b0;
    logic         reset, enable, clear_stats, in_valid, in_ready;
    logic         out_valid, out_ready, mismatch;
    logic [3:0]   conv_mask;
    logic [255:0] in_data, out_data;
    logic [31:0]  hole_count;

    int total = 0;
    int bad   = 0;

    logic [255:0] exp_q [$];
    logic [63:0]  part_q [$];   // one compacted position per entry: {ch3, ch2, ch1, ch0}
    logic         en_m   = 1'b0;
    logic [31:0]  hole_m = '0;
    logic         mm_m   = 1'b0;

    rx_fsrc dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .conv_mask  (conv_mask),
        .clear_stats(clear_stats),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .hole_count (hole_count),
        .mismatch   (mismatch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Same sample pattern on every channel, channel c offset by c*0x1000; holes stay 0x8000.
    function automatic logic [255:0] mk(input logic [15:0] s0, input logic [15:0] s1,
                                        input logic [15:0] s2, input logic [15:0] s3);
        logic [15:0]  s [4];
        logic [255:0] r;
        s = '{s0, s1, s2, s3};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) begin
                r[c*64 + j*16 +: 16] = (s[j] === H) ? H : s[j] + (16'(c) << 12);
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        logic [3:0]   pat [4];
        logic [3:0]   rp;
        logic         tog, mm_hit, accept;
        int           fill, cnt;
        logic [63:0]  ent;
        logic [255:0] b;
        if (reset) begin
            check("rst_in_ready", in_ready, 1'b0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_hole_count", hole_count, 32'd0);
            check("rst_mismatch", mismatch, 1'b0);
            exp_q.delete();
            part_q.delete();
            en_m   = 1'b0;
            hole_m = '0;
            mm_m   = 1'b0;
        end else begin
            fill = 4 * exp_q.size() + part_q.size();
            tog  = (enable !== en_m);
            check("out_valid", out_valid, fill >= 4);
            check("in_ready", in_ready, !tog && (fill < 4 || out_ready));
            check("hole_count", hole_count, hole_m);
            check("mismatch", mismatch, mm_m);
            if (out_valid && out_ready) begin
                check("out_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
            end
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    pat[c][j] = (in_data[c*64 + j*16 +: 16] === H);
            rp = pat[0];
            for (int c = 3; c >= 0; c--) if (conv_mask[c]) rp = pat[c];
            mm_hit = 1'b0;
            for (int c = 0; c < 4; c++) if (conv_mask[c] && pat[c] !== rp) mm_hit = 1'b1;
            accept = in_valid && in_ready;
            if (clear_stats) begin
                hole_m = '0;
                mm_m   = 1'b0;
            end else if (accept && en_m) begin
                cnt = $countones(rp);
                if (hole_m > 32'hFFFF_FFFF - 32'(cnt)) hole_m = 32'hFFFF_FFFF;
                else hole_m = hole_m + 32'(cnt);
                if (mm_hit) mm_m = 1'b1;
            end
            if (tog) begin
                exp_q.delete();
                part_q.delete();
            end else if (accept) begin
                for (int j = 0; j < 4; j++) begin
                    if (!(en_m && rp[j])) begin
                        for (int c = 0; c < 4; c++) ent[c*16 +: 16] = in_data[c*64 + j*16 +: 16];
                        part_q.push_back(ent);
                    end
                end
                while (part_q.size() >= 4) begin
                    for (int k = 0; k < 4; k++) begin
                        ent = part_q.pop_front();
                        for (int c = 0; c < 4; c++) b[c*64 + k*16 +: 16] = ent[c*16 +: 16];
                    end
                    exp_q.push_back(b);
                end
            end
            en_m = enable;
        end
    end

    // Presents one beat from posedge+1 until accepted; returns at posedge+1.
    task automatic send(input logic [255:0] d);
        logic accepted;
        accepted = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_accepted", accepted, 1'b1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [255:0] a, b, c, mb;
        reset = 1'b1; enable = 1'b0; conv_mask = 4'hF; clear_stats = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);
        next_cycle();

        // Bypass: three back-to-back beats pass unchanged with one cycle of latency.
        a = mk(16'h0a01, 16'h0a02, 16'h0a03, 16'h0a04);
        b = mk(16'h0b01, 16'h0b02, 16'h0b03, 16'h0b04);
        c = mk(16'h0c01, 16'h0c02, 16'h0c03, 16'h0c04);
        send(a); send(b); send(c);
        @(negedge clk);
        check("bypass_c", out_data, c);
        check("bypass_holes", hole_count, 32'd0);
        next_cycle();

        // Enable switch blocks the input for exactly that cycle.
        enable = 1'b1;
        @(negedge clk);
        check("toggle_in_ready", in_ready, 1'b0);
        next_cycle();

        // Compaction.
        send(mk(16'd1, H, 16'd3, 16'd4));
        send(mk(16'd5, 16'd6, H, 16'd8));
        @(negedge clk);
        check("compact_valid", out_valid, 1'b1);
        check("compact_ch0", out_data[63:0], {16'd5, 16'd4, 16'd3, 16'd1});
        check("compact_holes", hole_count, 32'd2);
        next_cycle();
        @(negedge clk);
        check("compact_fill2", out_valid, 1'b0);
        next_cycle();

        // All-hole beat: accepted, fill unchanged, four holes counted.
        send(mk(H, H, H, H));
        @(negedge clk);
        check("allhole_valid", out_valid, 1'b0);
        check("allhole_holes", hole_count, 32'd6);
        next_cycle();
        send(mk(16'd9, 16'd10, 16'd11, 16'd12));
        @(negedge clk);
        check("after_allhole_ch0", out_data[63:0], {16'd10, 16'd9, 16'd8, 16'd6});
        next_cycle();

        // Backpressure with fill=5.
        out_ready = 1'b0;
        send(mk(16'd13, 16'd14, 16'd15, H));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_data", out_data, mk(16'd11, 16'd12, 16'd13, 16'd14));
            next_cycle();
        end
        out_ready = 1'b1;
        next_cycle();
        next_cycle();

        // Mismatch: ch0 hole at 2, ch1 hole at 1, only ch0/ch1 enabled.
        conv_mask = 4'b0011;
        mb = mk(16'h21, 16'h22, H, 16'h24);
        mb[64 +: 64] = {16'h1124, 16'h1123, H, 16'h1121};
        send(mb);
        @(negedge clk);
        check("mismatch_set", mismatch, 1'b1);
        next_cycle();
        send(mk(16'h31, 16'h32, 16'h33, 16'h34));
        next_cycle();
        @(negedge clk);
        check("mismatch_held", mismatch, 1'b1);
        check("holes_before_clear", hole_count, 32'd8);
        next_cycle();
        clear_stats = 1'b1;
        next_cycle();
        clear_stats = 1'b0;
        @(negedge clk);
        check("mismatch_cleared", mismatch, 1'b0);
        check("holes_cleared", hole_count, 32'd0);
        next_cycle();

        // Enable 1->0 with two partial samples: they are dropped.
        conv_mask = 4'hF;
        send(mk(16'h41, H, H, 16'h44));
        @(negedge clk);
        check("partial_not_valid", out_valid, 1'b0);
        next_cycle();
        enable = 1'b0;
        @(negedge clk);
        check("toggle_off_in_ready", in_ready, 1'b0);
        next_cycle();
        a = mk(16'h51, 16'h52, 16'h53, 16'h54);
        send(a);
        @(negedge clk);
        check("after_toggle_data", out_data, a);
        next_cycle();

        // Reset with two partial samples buffered.
        enable = 1'b1;
        send(mk(16'h61, H, H, 16'h64));
        reset  = 1'b1;
        enable = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rst2_in_ready", in_ready, 1'b1);
        check("rst2_out_valid", out_valid, 1'b0);
        next_cycle();
        b = mk(16'h71, 16'h72, 16'h73, 16'h74);
        send(b);
        @(negedge clk);
        check("after_rst_data", out_data, b);
        next_cycle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
